led_pattern_gen: RTL and testbench

LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

---
 rtl/led_pkg.sv | 30 +++
 rtl/led_tick_div.sv | 38 +++
 rtl/led_pattern_gen.sv | 124 ++++++++++++
 tb/tb_led_pattern_gen.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared display-mode encoding and ring/base-pattern geometry for the LED pattern generator.
// Pure combinational helpers; no state.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_STATIC = 2'd1,
    MODE_GROW   = 2'd2,
    MODE_SCROLL = 2'd3
  } mode_e;

  // Distance of a pixel from the nearest edge; concentric rings count inward from 0.
  function automatic int ring(input int r, input int c, input int rows, input int cols);
    int m;
    m = r;
    if (c < m) m = c;
    if (rows - 1 - r < m) m = rows - 1 - r;
    if (cols - 1 - c < m) m = cols - 1 - c;
    return m;
  endfunction

  function automatic logic base_red(input int r, input int c, input int rows, input int cols);
    return (ring(r, c, rows, cols) % 2) == 0;
  endfunction

  function automatic logic base_grn(input int r, input int c, input int rows, input int cols);
    return (ring(r, c, rows, cols) % 2) == 1;
  endfunction

endpackage

// File: rtl/led_tick_div.sv
// Prescaler: counts 0..TICK_DIV-1 and emits a combinational one-cycle tick at the terminal count.
// No backpressure; hold freezes the count, clr zeroes it and suppresses the tick that cycle.
module led_tick_div #(
  parameter int TICK_DIV = 1000
) (
  input  logic clk,
  input  logic RST_n,
  input  logic clr,
  input  logic hold,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = 1'b0;
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (!hold) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_pattern_gen.sv
// LED matrix pattern generator: OFF / STATIC rings / GROW rings / SCROLL, stepped by a prescaled tick.
// Pixels are registered one cycle after mode/step; freeze holds the animation, a mode change clears it.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int ROWS     = 16,
  parameter int COLS     = 16,
  parameter int TICK_DIV = 1000
) (
  input  logic                       clk,
  input  logic                       RST_n,
  input  logic [1:0]                 mode,
  input  logic                       freeze,
  output logic [ROWS-1:0][COLS-1:0]  RedPixels,
  output logic [ROWS-1:0][COLS-1:0]  GrnPixels,
  output logic                       frame_done
);

  localparam int NRINGS = ((ROWS < COLS) ? ROWS : COLS) / 2;
  localparam int SW     = $clog2(COLS);

  mode_e                     state_q, state_d;
  logic [SW-1:0]             step_q, step_d, step_max;
  logic                      run;
  logic                      clr, tick;
  logic                      frame_done_q, frame_done_d;
  logic [ROWS-1:0][COLS-1:0] red_q, red_d, grn_q, grn_d;

  // A mode change is seen on the same edge that registers it.
  assign clr = (state_d != state_q);

  led_tick_div #(.TICK_DIV(TICK_DIV)) u_tick_div (
    .clk   (clk),
    .RST_n (RST_n),
    .clr   (clr),
    .hold  (freeze),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) state_q <= MODE_OFF;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = mode_e'(mode);
  end

  always_comb begin
    run      = 1'b0;
    step_max = '0;
    case (state_q)
      MODE_GROW: begin
        run      = 1'b1;
        step_max = SW'(NRINGS);
      end
      MODE_SCROLL: begin
        run      = 1'b1;
        step_max = SW'(COLS - 1);
      end
      default: ;
    endcase
  end

  always_comb begin
    step_d       = step_q;
    frame_done_d = 1'b0;
    if (clr || !run) begin
      step_d = '0;
    end else if (tick) begin
      if (step_q == step_max) begin
        step_d       = '0;
        frame_done_d = 1'b1;
      end else begin
        step_d = step_q + SW'(1);
      end
    end
  end

  always_comb begin
    red_d = '0;
    grn_d = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        case (state_q)
          MODE_STATIC: begin
            red_d[r][c] = base_red(r, c, ROWS, COLS);
            grn_d[r][c] = base_grn(r, c, ROWS, COLS);
          end
          MODE_GROW: begin
            if (ring(r, c, ROWS, COLS) < int'(step_q)) begin
              red_d[r][c] = base_red(r, c, ROWS, COLS);
              grn_d[r][c] = base_grn(r, c, ROWS, COLS);
            end
          end
          MODE_SCROLL: begin
            red_d[r][c] = base_red(r, (c + int'(step_q)) % COLS, ROWS, COLS);
            grn_d[r][c] = base_grn(r, (c + int'(step_q)) % COLS, ROWS, COLS);
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      step_q       <= '0;
      frame_done_q <= 1'b0;
      red_q        <= '0;
      grn_q        <= '0;
    end else begin
      step_q       <= step_d;
      frame_done_q <= frame_done_d;
      red_q        <= red_d;
      grn_q        <= grn_d;
    end
  end

  assign RedPixels  = red_q;
  assign GrnPixels  = grn_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed self-checking bench for led_pattern_gen at 16x16, TICK_DIV=4.
module tb_led_pattern_gen;

  logic                clk = 1'b0;
  logic                RST_n = 1'b0;
  logic [1:0]          mode = 2'd0;
  logic                freeze = 1'b0;
  logic [15:0][15:0]   RedPixels;
  logic [15:0][15:0]   GrnPixels;
  logic                frame_done;

  int n_tests = 0;
  int n_fail  = 0;
  int fd_count = 0;
  int fd0;
  int bad;

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) fd_count <= fd_count + 1;

  led_pattern_gen #(.ROWS(16), .COLS(16), .TICK_DIV(4)) dut (
    .clk        (clk),
    .RST_n      (RST_n),
    .mode       (mode),
    .freeze     (freeze),
    .RedPixels  (RedPixels),
    .GrnPixels  (GrnPixels),
    .frame_done (frame_done)
  );

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Independent reference for the concentric ring pattern of one row.
  function automatic logic [15:0] base_row(input int r, input bit red);
    logic [15:0] v;
    int k;
    v = '0;
    for (int c = 0; c < 16; c++) begin
      k = r;
      if (15 - r < k) k = 15 - r;
      if (c < k) k = c;
      if (15 - c < k) k = 15 - c;
      v[c] = red ? (k % 2 == 0) : (k % 2 == 1);
    end
    return v;
  endfunction

  task automatic test_reset;
    #2;
    n_tests++;
    if (RedPixels !== '0 || GrnPixels !== '0 || frame_done !== 1'b0) begin
      n_fail++; $display("FAIL reset_state: red=%h grn=%h fd=%b, expected all 0", RedPixels, GrnPixels, frame_done);
    end
    cyc(2); RST_n = 1'b1; cyc(2);
    mode = 2'd3;
    cyc(22);
    n_tests++;
    if (RedPixels === '0) begin
      n_fail++; $display("FAIL reset_scroll_active: red=%h, expected nonzero", RedPixels);
    end
    fd0 = fd_count;
    RST_n = 1'b0;
    #1;
    n_tests++;
    if (RedPixels !== '0 || GrnPixels !== '0 || frame_done !== 1'b0) begin
      n_fail++; $display("FAIL reset_async: red=%h grn=%h fd=%b, expected all 0", RedPixels, GrnPixels, frame_done);
    end
    cyc(3);
    RST_n = 1'b1;
    cyc(5);
    n_tests++;
    if (fd_count - fd0 !== 0) begin
      n_fail++; $display("FAIL reset_no_frame_done: pulses=%0d, expected 0", fd_count - fd0);
    end
    mode = 2'd0;
    cyc(2);
  endtask

  task automatic test_static;
    mode = 2'd0; cyc(2);
    fd0 = fd_count;
    mode = 2'd1; cyc(2);
    n_tests++;
    if (RedPixels[0] !== 16'hFFFF || GrnPixels[0] !== 16'h0000) begin
      n_fail++; $display("FAIL static_row0: red=%h grn=%h, expected ffff 0000", RedPixels[0], GrnPixels[0]);
    end
    n_tests++;
    if (RedPixels[1] !== 16'h8001 || GrnPixels[1] !== 16'h7FFE) begin
      n_fail++; $display("FAIL static_row1: red=%h grn=%h, expected 8001 7ffe", RedPixels[1], GrnPixels[1]);
    end
    n_tests++;
    if (RedPixels[15] !== 16'hFFFF) begin
      n_fail++; $display("FAIL static_row15: red=%h, expected ffff", RedPixels[15]);
    end
    cyc(40);
    bad = 0;
    for (int r = 0; r < 16; r++)
      if (RedPixels[r] !== base_row(r, 1'b1) || GrnPixels[r] !== base_row(r, 1'b0)) bad++;
    n_tests++;
    if (bad != 0 || fd_count - fd0 != 0) begin
      n_fail++; $display("FAIL static_hold: bad_rows=%0d pulses=%0d, expected 0 0", bad, fd_count - fd0);
    end
  endtask

  task automatic test_off;
    mode = 2'd0; cyc(2);
    n_tests++;
    if (RedPixels !== '0 || GrnPixels !== '0) begin
      n_fail++; $display("FAIL off_dark: red=%h grn=%h, expected 0", RedPixels, GrnPixels);
    end
  endtask

  task automatic test_grow;
    mode = 2'd0; cyc(2);
    fd0 = fd_count;
    mode = 2'd2; cyc(1);
    cyc(1);
    n_tests++;
    if (RedPixels !== '0 || GrnPixels !== '0) begin
      n_fail++; $display("FAIL grow_step0_dark: red=%h grn=%h, expected 0", RedPixels, GrnPixels);
    end
    cyc(4);
    n_tests++;
    if (RedPixels[0] !== 16'hFFFF || GrnPixels[1] !== 16'h0000 || RedPixels[1] !== 16'h8001) begin
      n_fail++; $display("FAIL grow_step1: red0=%h grn1=%h red1=%h, expected ffff 0000 8001", RedPixels[0], GrnPixels[1], RedPixels[1]);
    end
    cyc(28);
    bad = 0;
    for (int r = 0; r < 16; r++)
      if (RedPixels[r] !== base_row(r, 1'b1) || GrnPixels[r] !== base_row(r, 1'b0)) bad++;
    n_tests++;
    if (bad != 0 || fd_count - fd0 != 0) begin
      n_fail++; $display("FAIL grow_step8_full: bad_rows=%0d pulses=%0d, expected 0 0", bad, fd_count - fd0);
    end
    cyc(2);
    n_tests++;
    if (frame_done !== 1'b0) begin
      n_fail++; $display("FAIL grow_fd_early: fd=%b, expected 0", frame_done);
    end
    cyc(1);
    n_tests++;
    if (frame_done !== 1'b1) begin
      n_fail++; $display("FAIL grow_fd_wrap: fd=%b, expected 1", frame_done);
    end
    cyc(1);
    n_tests++;
    if (frame_done !== 1'b0 || RedPixels !== '0 || GrnPixels !== '0 || fd_count - fd0 != 1) begin
      n_fail++; $display("FAIL grow_after_wrap: fd=%b red=%h pulses=%0d, expected 0 0 1", frame_done, RedPixels, fd_count - fd0);
    end
    cyc(35);
    n_tests++;
    if (frame_done !== 1'b1) begin
      n_fail++; $display("FAIL grow_period36: fd=%b, expected 1", frame_done);
    end
  endtask

  task automatic test_scroll;
    mode = 2'd0; cyc(2);
    fd0 = fd_count;
    mode = 2'd3; cyc(1);
    cyc(1);
    n_tests++;
    if (RedPixels[1] !== 16'h8001 || GrnPixels[1] !== 16'h7FFE) begin
      n_fail++; $display("FAIL scroll_step0: red1=%h grn1=%h, expected 8001 7ffe", RedPixels[1], GrnPixels[1]);
    end
    cyc(4);
    n_tests++;
    if (RedPixels[1] !== 16'hC000 || GrnPixels[1] !== 16'h3FFF || RedPixels[0] !== 16'hFFFF) begin
      n_fail++; $display("FAIL scroll_step1: red1=%h grn1=%h red0=%h, expected c000 3fff ffff", RedPixels[1], GrnPixels[1], RedPixels[0]);
    end
    cyc(4);
    n_tests++;
    if (RedPixels[1] !== 16'h6000 || GrnPixels[1] !== 16'h9FFF) begin
      n_fail++; $display("FAIL scroll_step2: red1=%h grn1=%h, expected 6000 9fff", RedPixels[1], GrnPixels[1]);
    end
    cyc(55);
    n_tests++;
    if (frame_done !== 1'b1) begin
      n_fail++; $display("FAIL scroll_fd_wrap: fd=%b, expected 1", frame_done);
    end
    cyc(1);
    bad = 0;
    for (int r = 0; r < 16; r++)
      if (RedPixels[r] !== base_row(r, 1'b1) || GrnPixels[r] !== base_row(r, 1'b0)) bad++;
    n_tests++;
    if (bad != 0 || fd_count - fd0 != 1 || frame_done !== 1'b0) begin
      n_fail++; $display("FAIL scroll_back_to_base: bad_rows=%0d pulses=%0d fd=%b, expected 0 1 0", bad, fd_count - fd0, frame_done);
    end
  endtask

  task automatic test_freeze;
    mode = 2'd0; cyc(2);
    fd0 = fd_count;
    mode = 2'd2; cyc(1);
    cyc(12);
    freeze = 1'b1;
    cyc(1);
    n_tests++;
    if (RedPixels[2] !== 16'hBFFD || GrnPixels[2] !== 16'h4002 || RedPixels[3] !== 16'hA005 || GrnPixels[3] !== 16'h4002) begin
      n_fail++; $display("FAIL freeze_step3: r2=%h g2=%h r3=%h g3=%h, expected bffd 4002 a005 4002", RedPixels[2], GrnPixels[2], RedPixels[3], GrnPixels[3]);
    end
    cyc(19);
    n_tests++;
    if (RedPixels[2] !== 16'hBFFD || GrnPixels[2] !== 16'h4002 || RedPixels[3] !== 16'hA005 || GrnPixels[3] !== 16'h4002 || fd_count - fd0 != 0) begin
      n_fail++; $display("FAIL freeze_hold: r2=%h g2=%h r3=%h g3=%h pulses=%0d, expected bffd 4002 a005 4002 0", RedPixels[2], GrnPixels[2], RedPixels[3], GrnPixels[3], fd_count - fd0);
    end
    freeze = 1'b0;
    cyc(4);
    n_tests++;
    if (GrnPixels[3] !== 16'h4002) begin
      n_fail++; $display("FAIL freeze_release_early: g3=%h, expected 4002", GrnPixels[3]);
    end
    cyc(1);
    n_tests++;
    if (GrnPixels[3] !== 16'h5FFA || RedPixels[3] !== 16'hA005) begin
      n_fail++; $display("FAIL freeze_release_step4: g3=%h r3=%h, expected 5ffa a005", GrnPixels[3], RedPixels[3]);
    end
  endtask

  task automatic test_mode_switch;
    mode = 2'd0; cyc(2);
    fd0 = fd_count;
    mode = 2'd2; cyc(1);
    cyc(20);
    mode = 2'd3;
    cyc(1);
    n_tests++;
    if (frame_done !== 1'b0) begin
      n_fail++; $display("FAIL switch_no_fd: fd=%b, expected 0", frame_done);
    end
    cyc(1);
    n_tests++;
    if (RedPixels[1] !== 16'h8001 || GrnPixels[1] !== 16'h7FFE) begin
      n_fail++; $display("FAIL switch_step_cleared: red1=%h grn1=%h, expected 8001 7ffe", RedPixels[1], GrnPixels[1]);
    end
    cyc(3);
    n_tests++;
    if (RedPixels[1] !== 16'h8001) begin
      n_fail++; $display("FAIL switch_tick_early: red1=%h, expected 8001", RedPixels[1]);
    end
    cyc(1);
    n_tests++;
    if (RedPixels[1] !== 16'hC000 || fd_count - fd0 != 0) begin
      n_fail++; $display("FAIL switch_first_tick: red1=%h pulses=%0d, expected c000 0", RedPixels[1], fd_count - fd0);
    end
  endtask

  initial begin
    test_reset;
    test_static;
    test_off;
    test_grow;
    test_scroll;
    test_freeze;
    test_mode_switch;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
